sram_fifo_sched: RTL and testbench
==================================

SRAM_FIFO_SCHED -- requirements
Module: sram_fifo_sched

Interface
REQ-001 Parameter ADDR_W, default 19: SRAM word address width; ring depth SHALL be 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 144: word width.
REQ-003 Parameter CREDITS, default 8: maximum reads issued and not yet released by the consumer.
REQ-004 clk  in  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1: synchronous, active-low reset.
REQ-006 calib_done  in  1: memory controller calibration complete.
REQ-007 s0_data  in  DATA_W: requester 0 write word.
REQ-008 s0_valid  in  1: requester 0 word valid.
REQ-009 s0_ready  out  1: requester 0 word accepted this cycle when high with s0_valid.
REQ-010 s1_data  in  DATA_W: requester 1 write word.
REQ-011 s1_valid  in  1: requester 1 word valid.
REQ-012 s1_ready  out  1: requester 1 word accepted this cycle when high with s1_valid.
REQ-013 app_wr_cmd  out  1: one-cycle write command to controller port 0.
REQ-014 app_wr_addr  out  ADDR_W: write address.
REQ-015 app_wr_data  out  DATA_W: write data.
REQ-016 app_rd_cmd  out  1: one-cycle read command to controller port 0.
REQ-017 app_rd_addr  out  ADDR_W: read address.
REQ-018 app_rd_valid  in  1: read data returned by controller.
REQ-019 credit_ret  in  1: consumer released one returned word.
REQ-020 level  out  ADDR_W+1: words written and not yet read-issued.
REQ-021 err  out  1: sticky protocol error.
REQ-022 stat_wr, stat_rd  out  32 each: accepted-write and issued-read counters.

Function
REQ-023 FSM states INIT, RUN, HALT; INIT->RUN when calib_done=1; RUN->HALT when calib_done=0; HALT->INIT when inflight=0.
REQ-024 Outside RUN: s0_ready=s1_ready=0, app_wr_cmd=0, app_rd_cmd=0; addresses, level, credits held.
REQ-025 Write grant: combinational, at most one requester per cycle; only in RUN and level<2^ADDR_W (not full).
REQ-026 One requester valid: that one granted; both valid: granted to the one not granted most recently (round-robin pointer updated only on an accepted write; reset pointer favours s0).
REQ-027 Accepted write: app_wr_cmd=1 same cycle, app_wr_addr=wr_ptr, app_wr_data=granted data; wr_ptr increments, wrapping 2^ADDR_W-1->0.
REQ-028 Read issue: app_rd_cmd=1 in RUN when level>0 (registered value) and credit>0; app_rd_addr=rd_ptr; rd_ptr increments with same wrap.
REQ-029 Word written in cycle N SHALL be read-issuable no earlier than cycle N+1.
REQ-030 Write and read in the same cycle: both issued, level unchanged; write only +1; read only -1.
REQ-031 credit: -1 on app_rd_cmd, +1 on credit_ret, unchanged if both; credit_ret when credit=CREDITS SHALL be ignored and set err.
REQ-032 inflight: +1 on app_rd_cmd, -1 on app_rd_valid; app_rd_valid when inflight=0 SHALL be ignored and set err.
REQ-033 calib_done falling mid-stream: commands already issued complete; no new commands until INIT->RUN again; pointers preserved.

Reset
REQ-034 rst_n=0 at a clock edge: state=INIT, wr_ptr=rd_ptr=0, level=0, credit=CREDITS, inflight=0, err=0, RR pointer=s0, stat_wr=stat_rd=0.
REQ-035 During and the cycle after reset all command and ready outputs SHALL be 0; reset mid-stream discards all contents.

Configuration
REQ-036 SRAM_FIFO_SCHED_STATS_EN defined: stat_wr/stat_rd SHALL count accepted writes/issued reads, saturating at 0xFFFFFFFF; undefined: counters SHALL not exist and outputs SHALL be constant 0.

Verification
REQ-037 calib_done=0, s0_valid=1 for 20 cycles -> s0_ready=0, app_wr_cmd=0 throughout; calib_done=1 -> first write next RUN cycle at addr 0.
REQ-038 s0,s1 valid continuously, 6 cycles -> grants s0,s1,s0,s1,s0,s1; addrs 0..5; level=6 before any read.
REQ-039 CREDITS=8, no credit_ret, 20 words written -> exactly 8 app_rd_cmd (addr 0..7), then stall; one credit_ret -> one more read at addr 8.
REQ-040 ADDR_W=4: fill 16 words -> s*_ready=0; reads drain; writes wrap to addr 0 after addr 15.
REQ-041 credit_ret with credit=CREDITS, and app_rd_valid with inflight=0 -> err=1 and stays 1 until rst_n=0.
REQ-042 calib_done drops with 3 reads inflight -> HALT, no commands; 3 app_rd_valid -> INIT; calib_done=1 -> reads resume at next rd_ptr.

Source files
------------

// File: rtl/sram_fifo_sched.sv
// ============================================================================
// Module      : sram_fifo_sched
// Description : Two-requester round-robin write scheduler over an SRAM ring
//               buffer with credit-limited read issue. Optional statistics
//               counters are enabled by defining SRAM_FIFO_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_fifo_sched #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 144,
  parameter int CREDITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  output logic              app_wr_cmd,
  output logic [ADDR_W-1:0] app_wr_addr,
  output logic [DATA_W-1:0] app_wr_data,
  output logic              app_rd_cmd,
  output logic [ADDR_W-1:0] app_rd_addr,
  input  logic              app_rd_valid,
  input  logic              credit_ret,
  output logic [ADDR_W:0]   level,
  output logic              err,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_rd
);

  localparam int              c_CW      = $clog2(CREDITS + 1);
  localparam logic [c_CW-1:0] c_CREDITS = c_CW'(CREDITS);
  localparam logic [ADDR_W:0] c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [c_CW-1:0]   r_credit;
  logic [ADDR_W:0]   r_inflight;
  logic              r_err;
  logic              r_rr;       // 1: s1 wins the next contended cycle

  logic w_run, w_full, w_gnt0, w_gnt1, w_wr, w_rd, w_ret_ok, w_val_ok;

  // Gating with rst_n keeps every command low while reset is asserted.
  assign w_run    = rst_n && (r_state == S_RUN);
  assign w_full   = (r_level == c_DEPTH);
  assign w_gnt0   = w_run && !w_full && s0_valid && (!s1_valid || !r_rr);
  assign w_gnt1   = w_run && !w_full && s1_valid && (!s0_valid || r_rr);
  assign w_wr     = w_gnt0 || w_gnt1;
  assign w_rd     = w_run && (r_level != '0) && (r_credit != '0);
  assign w_ret_ok = credit_ret && (r_credit != c_CREDITS);
  assign w_val_ok = app_rd_valid && (r_inflight != '0);

  assign s0_ready    = w_gnt0;
  assign s1_ready    = w_gnt1;
  assign app_wr_cmd  = w_wr;
  assign app_wr_addr = r_wr_ptr;
  assign app_wr_data = w_gnt1 ? s1_data : s0_data;
  assign app_rd_cmd  = w_rd;
  assign app_rd_addr = r_rd_ptr;
  assign level       = r_level;
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_credit   <= c_CREDITS;
      r_inflight <= '0;
      r_err      <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      case (r_state)
        S_INIT:  if (calib_done) r_state <= S_RUN;
        S_RUN:   if (!calib_done) r_state <= S_HALT;
        S_HALT:  if (r_inflight == '0) r_state <= S_INIT;
        default: r_state <= S_INIT;
      endcase

      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr     <= w_gnt0;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_wr && !w_rd)      r_level <= r_level + 1'b1;
      else if (!w_wr && w_rd) r_level <= r_level - 1'b1;

      if (w_ret_ok && !w_rd)      r_credit <= r_credit + 1'b1;
      else if (!w_ret_ok && w_rd) r_credit <= r_credit - 1'b1;

      if (w_rd && !w_val_ok)      r_inflight <= r_inflight + 1'b1;
      else if (!w_rd && w_val_ok) r_inflight <= r_inflight - 1'b1;

      // Releases with nothing outstanding are dropped but remembered.
      if ((credit_ret && !w_ret_ok) || (app_rd_valid && !w_val_ok)) r_err <= 1'b1;
    end
  end

`ifdef SRAM_FIFO_SCHED_STATS_EN
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
    end else begin
      if (w_wr && !(&r_stat_wr)) r_stat_wr <= r_stat_wr + 1'b1;
      if (w_rd && !(&r_stat_rd)) r_stat_rd <= r_stat_rd + 1'b1;
    end
  end

  assign stat_wr = r_stat_wr;
  assign stat_rd = r_stat_rd;
`else
  assign stat_wr = '0;
  assign stat_rd = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_fifo_sched.sv
// ============================================================================
// Module      : tb_sram_fifo_sched
// Description : Self-checking bench for sram_fifo_sched with a queue-based
//               reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_fifo_sched;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;
  localparam int CREDITS = 8;
  localparam int DEPTH   = 16;
`ifdef SRAM_FIFO_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, calib_done, s0_valid, s1_valid, app_rd_valid, credit_ret;
  logic [DATA_W-1:0] s0_data, s1_data, app_wr_data;
  logic s0_ready, s1_ready, app_wr_cmd, app_rd_cmd, err;
  logic [ADDR_W-1:0] app_wr_addr, app_rd_addr;
  logic [ADDR_W:0] level;
  logic [31:0] stat_wr, stat_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_fifo_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .app_wr_cmd(app_wr_cmd), .app_wr_addr(app_wr_addr), .app_wr_data(app_wr_data),
    .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr), .app_rd_valid(app_rd_valid),
    .credit_ret(credit_ret), .level(level), .err(err),
    .stat_wr(stat_wr), .stat_rd(stat_rd)
  );

  // Reference model: state 0=INIT 1=RUN 2=HALT; the ring contents are a queue of addresses.
  int m_state, m_wcnt, m_credit, m_inflight, m_last, m_swr, m_srd;
  int m_q[$];
  bit m_err;
  logic e_g0, e_g1, e_wr, e_rd;
  logic [ADDR_W-1:0] e_wr_addr, e_rd_addr;
  logic [DATA_W-1:0] e_wr_data;
  logic [ADDR_W:0] e_level;

  task automatic model_eval();
    bit run, full;
    run  = rst_n && (m_state == 1);
    full = (m_q.size() == DEPTH);
    e_g0 = run && !full && s0_valid && (!s1_valid || m_last == 1);
    e_g1 = run && !full && s1_valid && (!s0_valid || m_last == 0);
    e_wr = e_g0 || e_g1;
    e_wr_addr = ADDR_W'(m_wcnt % DEPTH);
    e_wr_data = e_g1 ? s1_data : s0_data;
    e_rd = run && (m_q.size() > 0) && (m_credit > 0);
    e_rd_addr = (m_q.size() > 0) ? ADDR_W'(m_q[0]) : '0;
    e_level = (ADDR_W+1)'(m_q.size());
  endtask

  task automatic model_commit();
    int nxt;
    if (!rst_n) begin
      m_state = 0; m_q.delete(); m_wcnt = 0; m_credit = CREDITS; m_inflight = 0;
      m_err = 1'b0; m_last = 1; m_swr = 0; m_srd = 0;
      return;
    end
    nxt = m_state;
    if (m_state == 0 && calib_done) nxt = 1;
    if (m_state == 1 && !calib_done) nxt = 2;
    if (m_state == 2 && m_inflight == 0) nxt = 0;
    if (credit_ret) begin
      if (m_credit == CREDITS) m_err = 1'b1; else m_credit++;
    end
    if (app_rd_valid) begin
      if (m_inflight == 0) m_err = 1'b1; else m_inflight--;
    end
    if (e_rd) begin
      void'(m_q.pop_front()); m_credit--; m_inflight++; m_srd++;
    end
    if (e_wr) begin
      m_q.push_back(m_wcnt % DEPTH); m_wcnt++; m_last = e_g0 ? 0 : 1; m_swr++;
    end
    m_state = nxt;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    calib_done = 0; s0_valid = 0; s1_valid = 0; app_rd_valid = 0; credit_ret = 0;
    s0_data = '0; s1_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 0; clear_inputs();
    sample(); step(); sample(); step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs(); calib_done = 1; s0_valid = 1; s1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++; if ({s0_ready, s1_ready, app_wr_cmd, app_rd_cmd} !== 4'b0) begin
        failures++; $display("FAIL reset_outputs got=%b exp=0000", {s0_ready, s1_ready, app_wr_cmd, app_rd_cmd}); end
      step();
    end
    rst_n = 1;
    sample();
    checks++; if ({s0_ready, s1_ready, app_wr_cmd, app_rd_cmd} !== 4'b0) begin
      failures++; $display("FAIL post_reset_outputs got=%b exp=0000", {s0_ready, s1_ready, app_wr_cmd, app_rd_cmd}); end
    checks++; if (level !== 5'd0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_level_err got=%0d/%b exp=0/0", level, err); end
    checks++; if (stat_wr !== 32'd0 || stat_rd !== 32'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_wr, stat_rd); end
    step();
    clear_inputs();
  endtask

  task automatic test_calib_gate();
    int first = -1;
    do_reset();
    s0_valid = 1;
    for (int i = 0; i < 20; i++) begin
      s0_data = DATA_W'($urandom);
      sample();
      checks++; if (s0_ready !== 1'b0 || app_wr_cmd !== 1'b0) begin
        failures++; $display("FAIL calib_gate cyc=%0d got=%b%b exp=00", i, s0_ready, app_wr_cmd); end
      step();
    end
    calib_done = 1;
    for (int i = 0; i < 5; i++) begin
      s0_data = DATA_W'($urandom);
      sample();
      checks++; if (app_wr_cmd !== e_wr) begin
        failures++; $display("FAIL calib_wr_cmd cyc=%0d got=%b exp=%b", i, app_wr_cmd, e_wr); end
      if (app_wr_cmd && first < 0) begin
        first = i;
        checks++; if (app_wr_addr !== 4'd0 || app_wr_data !== s0_data) begin
          failures++; $display("FAIL calib_first_wr got=%0d/%h exp=0/%h", app_wr_addr, app_wr_data, s0_data); end
      end
      step();
    end
    checks++; if (first != 1) begin
      failures++; $display("FAIL calib_first_cycle got=%0d exp=1", first); end
    clear_inputs();
  endtask

  task automatic test_credit();
    int writes = 0, reads = 0;
    do_reset();
    calib_done = 1;
    for (int i = 0; i < 40; i++) begin
      s0_valid = (writes < 20);
      s0_data = DATA_W'($urandom);
      sample();
      checks++; if (app_rd_cmd !== e_rd || app_wr_cmd !== e_wr) begin
        failures++; $display("FAIL credit_cmds cyc=%0d got=%b%b exp=%b%b", i, app_wr_cmd, app_rd_cmd, e_wr, e_rd); end
      if (app_wr_cmd) begin
        checks++; if (app_wr_addr !== ADDR_W'(writes % DEPTH)) begin
          failures++; $display("FAIL credit_wr_addr got=%0d exp=%0d", app_wr_addr, writes % DEPTH); end
        writes++;
      end
      if (app_rd_cmd) begin
        checks++; if (app_rd_addr !== ADDR_W'(reads)) begin
          failures++; $display("FAIL credit_rd_addr got=%0d exp=%0d", app_rd_addr, reads); end
        reads++;
      end
      step();
    end
    checks++; if (writes != 20 || reads != 8) begin
      failures++; $display("FAIL credit_stall got=%0d/%0d exp=20/8", writes, reads); end
    s0_valid = 0; credit_ret = 1;
    sample();
    checks++; if (app_rd_cmd !== 1'b0) begin
      failures++; $display("FAIL credit_ret_same_cycle got=%b exp=0", app_rd_cmd); end
    step();
    credit_ret = 0;
    sample();
    checks++; if (app_rd_cmd !== 1'b1 || app_rd_addr !== 4'd8) begin
      failures++; $display("FAIL credit_resume got=%b/%0d exp=1/8", app_rd_cmd, app_rd_addr); end
    step();
    sample();
    checks++; if (app_rd_cmd !== 1'b0) begin
      failures++; $display("FAIL credit_restall got=%b exp=0", app_rd_cmd); end
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    bit ready_ok = 0;
    do_reset();
    calib_done = 1;
    // Precondition: s1 alone consumes every credit, leaving the ring empty and s0 favoured.
    for (int i = 0; i < 40 && !ready_ok; i++) begin
      s1_valid = (m_wcnt < 8);
      s1_data = DATA_W'($urandom);
      sample(); step();
      ready_ok = (m_wcnt >= 8) && (m_q.size() == 0) && (m_credit == 0);
    end
    checks++; if (!ready_ok || level !== 5'd0) begin
      failures++; $display("FAIL rr_precondition got=%0d exp=0", level); end
    s0_valid = 1; s1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      s0_data = DATA_W'($urandom); s1_data = DATA_W'($urandom);
      sample();
      checks++; if (s0_ready !== ((i % 2) == 0) || s1_ready !== ((i % 2) == 1)) begin
        failures++; $display("FAIL rr_grant cyc=%0d got=%b%b exp=%b%b", i, s0_ready, s1_ready, (i % 2) == 0, (i % 2) == 1); end
      checks++; if (app_wr_addr !== ADDR_W'(8 + i) || app_wr_data !== ((i % 2) ? s1_data : s0_data) || app_rd_cmd !== 1'b0) begin
        failures++; $display("FAIL rr_write cyc=%0d got=%0d/%h/%b exp=%0d/%h/0", i, app_wr_addr, app_wr_data, app_rd_cmd, 8 + i, (i % 2) ? s1_data : s0_data); end
      step();
    end
    s0_valid = 0; s1_valid = 0;
    sample();
    checks++; if (level !== 5'd6) begin
      failures++; $display("FAIL rr_level got=%0d exp=6", level); end
    step();
  endtask

  task automatic test_full_wrap();
    int prev = -1;
    bit saw_wrap = 0, drained = 0;
    s0_valid = 1;
    for (int i = 0; i < 20 && m_q.size() < DEPTH; i++) begin
      s0_data = DATA_W'($urandom);
      sample();
      if (app_wr_cmd) begin
        if (prev == DEPTH - 1) begin
          saw_wrap = 1;
          checks++; if (app_wr_addr !== 4'd0) begin
            failures++; $display("FAIL wrap_addr got=%0d exp=0", app_wr_addr); end
        end
        prev = int'(app_wr_addr);
      end
      step();
    end
    checks++; if (!saw_wrap) begin
      failures++; $display("FAIL wrap_seen got=0 exp=1"); end
    s1_valid = 1;
    sample();
    checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || level !== 5'd16) begin
      failures++; $display("FAIL full_block got=%b%b/%0d exp=00/16", s0_ready, s1_ready, level); end
    step();
    s0_valid = 0; s1_valid = 0;
    for (int i = 0; i < 300 && !drained; i++) begin
      credit_ret = (m_credit < CREDITS) && ($urandom_range(0, 1) == 1);
      app_rd_valid = (m_inflight > 0) && ($urandom_range(0, 1) == 1);
      sample();
      checks++; if (app_rd_cmd !== e_rd || (e_rd && app_rd_addr !== e_rd_addr)) begin
        failures++; $display("FAIL drain_rd got=%b/%0d exp=%b/%0d", app_rd_cmd, app_rd_addr, e_rd, e_rd_addr); end
      step();
      drained = (m_q.size() == 0) && (m_inflight == 0) && (m_credit == CREDITS);
    end
    clear_inputs(); calib_done = 1;
    sample();
    checks++; if (!drained || level !== 5'd0) begin
      failures++; $display("FAIL drain_done got=%0d exp=0", level); end
    step();
    clear_inputs();
  endtask

  task automatic test_errors();
    do_reset();
    calib_done = 1; credit_ret = 1;
    sample(); step();
    credit_ret = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++; if (err !== 1'b1) begin
        failures++; $display("FAIL err_credit cyc=%0d got=%b exp=1", i, err); end
      step();
    end
    do_reset();
    sample();
    checks++; if (err !== 1'b0) begin
      failures++; $display("FAIL err_cleared got=%b exp=0", err); end
    step();
    app_rd_valid = 1;
    sample(); step();
    app_rd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++; if (err !== 1'b1) begin
        failures++; $display("FAIL err_inflight cyc=%0d got=%b exp=1", i, err); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    int reads = 0, first = -1;
    do_reset();
    calib_done = 1;
    for (int i = 0; i < 20 && !(m_wcnt == 3 && m_inflight == 3); i++) begin
      s0_valid = (m_wcnt < 3);
      s0_data = DATA_W'($urandom);
      sample();
      if (app_rd_cmd) reads++;
      step();
    end
    checks++; if (reads != 3) begin
      failures++; $display("FAIL halt_inflight got=%0d exp=3", reads); end
    s0_valid = 0; calib_done = 0;
    sample(); step();
    s0_valid = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++; if ({s0_ready, app_wr_cmd, app_rd_cmd} !== 3'b000) begin
        failures++; $display("FAIL halt_quiet cyc=%0d got=%b exp=000", i, {s0_ready, app_wr_cmd, app_rd_cmd}); end
      step();
    end
    s0_valid = 0; app_rd_valid = 1;
    repeat (3) begin sample(); step(); end
    app_rd_valid = 0; calib_done = 1; s0_valid = 1;
    for (int i = 0; i < 10; i++) begin
      s0_data = DATA_W'($urandom);
      sample();
      checks++; if (app_wr_cmd !== e_wr || app_rd_cmd !== e_rd) begin
        failures++; $display("FAIL halt_resume_cmds cyc=%0d got=%b%b exp=%b%b", i, app_wr_cmd, app_rd_cmd, e_wr, e_rd); end
      if (app_rd_cmd && first < 0) begin
        first = i;
        checks++; if (app_rd_addr !== 4'd3) begin
          failures++; $display("FAIL halt_resume_addr got=%0d exp=3", app_rd_addr); end
      end
      step();
    end
    checks++; if (first < 0) begin
      failures++; $display("FAIL halt_resume_seen got=none exp=read"); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    calib_done = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) calib_done = ~calib_done;
      s0_valid = $urandom_range(0, 1);
      s1_valid = $urandom_range(0, 2) != 0;
      s0_data = DATA_W'($urandom); s1_data = DATA_W'($urandom);
      credit_ret = (m_credit < CREDITS) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      app_rd_valid = (m_inflight > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      sample();
      checks++; if ({s0_ready, s1_ready, app_wr_cmd, app_rd_cmd} !== {e_g0, e_g1, e_wr, e_rd}) begin
        failures++; $display("FAIL rnd_cmds cyc=%0d got=%b exp=%b", i, {s0_ready, s1_ready, app_wr_cmd, app_rd_cmd}, {e_g0, e_g1, e_wr, e_rd}); end
      checks++; if ((e_wr && (app_wr_addr !== e_wr_addr || app_wr_data !== e_wr_data)) || (e_rd && app_rd_addr !== e_rd_addr)) begin
        failures++; $display("FAIL rnd_addr_data cyc=%0d got=%0d/%h/%0d exp=%0d/%h/%0d", i, app_wr_addr, app_wr_data, app_rd_addr, e_wr_addr, e_wr_data, e_rd_addr); end
      checks++; if (level !== e_level || err !== m_err) begin
        failures++; $display("FAIL rnd_level_err cyc=%0d got=%0d/%b exp=%0d/%b", i, level, err, e_level, m_err); end
      checks++; if (stat_wr !== (STATS ? 32'(m_swr) : 32'd0) || stat_rd !== (STATS ? 32'(m_srd) : 32'd0)) begin
        failures++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stat_wr, stat_rd, STATS ? m_swr : 0, STATS ? m_srd : 0); end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_calib_gate();
    test_credit();
    test_round_robin();
    test_full_wrap();
    test_errors();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
